// File: rtl/pw_capture_ctrl.sv
// Front-end sniff capture sequencer: arm, trigger, delay, then schedule
// DATA / TIME records into the sniff FIFO until length, abort or overflow.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for trigger
// DELAY   | counting trigger delay down to capture start
// CAPTURE | timestamping and writing data events
// DONE    | capture finished, counters held until next arm
module pw_capture_ctrl #(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pCOUNT_WIDTH           = 16
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic                    I_arm,
    input  logic                    I_abort,
    input  logic                    I_trigger,
    input  logic [pCOUNT_WIDTH-1:0] I_trigger_delay,
    input  logic [pCOUNT_WIDTH-1:0] I_capture_len,
    input  logic [7:0]              I_fe_data,
    input  logic                    I_fe_data_valid,
    input  logic                    I_fifo_full,
    output logic                    O_fifo_wr,
    output logic [17:0]             O_fifo_din,
    output logic                    O_capture_enable,
    output logic                    O_armed,
    output logic                    O_done,
    output logic                    O_overflow,
    output logic [pCOUNT_WIDTH-1:0] O_event_count
);
    localparam int F  = pTIMESTAMP_FULL_WIDTH;
    localparam int S  = pTIMESTAMP_SHORT_WIDTH;
    localparam int CW = pCOUNT_WIDTH;
    localparam logic [F-1:0] SHORT_MAX = F'((1 << S) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   delay_cnt, delay_cnt_nxt;
    logic [F-1:0]    delta, delta_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic [7:0]      pend_byte, pend_byte_nxt;
    logic            wr_nxt;
    logic [17:0]     din_nxt;
    logic            overflow_nxt;
    logic [CW-1:0]   count_nxt;
    logic            rec_valid;
    logic            rec_is_data;
    logic [17:0]     rec;
    logic            len_reached;

    assign len_reached = (I_capture_len != '0) && (O_event_count >= I_capture_len);

    always_comb begin
        state_nxt      = state;
        delay_cnt_nxt  = delay_cnt;
        delta_nxt      = (delta == {F{1'b1}}) ? delta : delta + 1'b1;
        pend_valid_nxt = pend_valid;
        pend_byte_nxt  = pend_byte;
        wr_nxt         = 1'b0;
        din_nxt        = '0;
        overflow_nxt   = O_overflow;
        count_nxt      = O_event_count;
        rec_valid      = 1'b0;
        rec_is_data    = 1'b0;
        rec            = '0;

        if (state != ST_CAPTURE)
            delta_nxt = '0;

        if (I_abort) begin
            state_nxt      = ST_IDLE;
            pend_valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (I_arm) begin
                        state_nxt    = ST_ARMED;
                        count_nxt    = '0;
                        overflow_nxt = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (I_trigger) begin
                        if (I_trigger_delay == '0) begin
                            state_nxt = ST_CAPTURE;
                        end else begin
                            state_nxt     = ST_DELAY;
                            delay_cnt_nxt = I_trigger_delay;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt <= CW'(1))
                        state_nxt = ST_CAPTURE;
                    else
                        delay_cnt_nxt = delay_cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    if (len_reached) begin
                        state_nxt = ST_DONE;
                    end else begin
                        // A latched byte owns the write slot; a new event now is lost.
                        if (pend_valid) begin
                            rec_valid      = 1'b1;
                            rec_is_data    = 1'b1;
                            rec[15:8]      = pend_byte;
                            pend_valid_nxt = 1'b0;
                            if (I_fe_data_valid) begin
                                overflow_nxt = 1'b1;
                                state_nxt    = ST_DONE;
                            end
                        end else if (I_fe_data_valid) begin
                            rec_valid = 1'b1;
                            if (delta <= SHORT_MAX) begin
                                rec_is_data  = 1'b1;
                                rec[15:8]    = I_fe_data;
                                rec[S-1:0]   = delta[S-1:0];
                            end else begin
                                rec[17:16]     = 2'b10;
                                rec[F-1:0]     = delta;
                                pend_valid_nxt = 1'b1;
                                pend_byte_nxt  = I_fe_data;
                            end
                        end
                        if (rec_valid) begin
                            if (I_fifo_full) begin
                                overflow_nxt   = 1'b1;
                                state_nxt      = ST_DONE;
                                pend_valid_nxt = 1'b0;
                            end else begin
                                wr_nxt  = 1'b1;
                                din_nxt = rec;
                                if (rec_is_data) begin
                                    delta_nxt = F'(1);
                                    count_nxt = (O_event_count == {CW{1'b1}}) ?
                                                O_event_count : O_event_count + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state            <= ST_IDLE;
            delay_cnt        <= '0;
            delta            <= '0;
            pend_valid       <= 1'b0;
            pend_byte        <= '0;
            O_fifo_wr        <= 1'b0;
            O_fifo_din       <= '0;
            O_capture_enable <= 1'b0;
            O_armed          <= 1'b0;
            O_done           <= 1'b0;
            O_overflow       <= 1'b0;
            O_event_count    <= '0;
        end else begin
            state            <= state_nxt;
            delay_cnt        <= delay_cnt_nxt;
            delta            <= delta_nxt;
            pend_valid       <= pend_valid_nxt;
            pend_byte        <= pend_byte_nxt;
            O_fifo_wr        <= wr_nxt;
            O_fifo_din       <= din_nxt;
            O_capture_enable <= (state_nxt == ST_CAPTURE);
            O_armed          <= (state_nxt == ST_ARMED) || (state_nxt == ST_DELAY);
            O_done           <= (state_nxt == ST_DONE);
            O_overflow       <= overflow_nxt;
            O_event_count    <= count_nxt;
        end
    end
endmodule

// File: tb/tb_pw_capture_ctrl.sv
// Scoreboard bench for pw_capture_ctrl: an event-list timestamp model queues
// expected FIFO records; a monitor pops and compares them on every write.
module tb_pw_capture_ctrl;
    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        I_arm, I_abort, I_trigger;
    logic [15:0] I_trigger_delay, I_capture_len;
    logic [7:0]  I_fe_data;
    logic        I_fe_data_valid, I_fifo_full;
    logic        O_fifo_wr;
    logic [17:0] O_fifo_din;
    logic        O_capture_enable, O_armed, O_done, O_overflow;
    logic [15:0] O_event_count;

    always #5 fe_clk = ~fe_clk;

    pw_capture_ctrl #(
        .pTIMESTAMP_FULL_WIDTH (16),
        .pTIMESTAMP_SHORT_WIDTH(3),
        .pCOUNT_WIDTH          (16)
    ) dut (
        .fe_clk          (fe_clk),
        .reset_i         (reset_i),
        .I_arm           (I_arm),
        .I_abort         (I_abort),
        .I_trigger       (I_trigger),
        .I_trigger_delay (I_trigger_delay),
        .I_capture_len   (I_capture_len),
        .I_fe_data       (I_fe_data),
        .I_fe_data_valid (I_fe_data_valid),
        .I_fifo_full     (I_fifo_full),
        .O_fifo_wr       (O_fifo_wr),
        .O_fifo_din      (O_fifo_din),
        .O_capture_enable(O_capture_enable),
        .O_armed         (O_armed),
        .O_done          (O_done),
        .O_overflow      (O_overflow),
        .O_event_count   (O_event_count)
    );

    typedef struct {
        logic [17:0] rec;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   dcyc     = 0;
    int   mcyc     = 0;
    int   m_anchor;
    int   m_count;
    int   m_last_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, dcyc);
        end
    endtask

    function automatic logic [17:0] data_rec(input logic [7:0] b, input int d);
        logic [2:0] sd;
        sd = d[2:0];
        return {2'b00, b, 5'b00000, sd};
    endfunction

    function automatic logic [17:0] time_rec(input int d);
        logic [15:0] fd;
        fd = d[15:0];
        return {2'b10, fd};
    endfunction

    task automatic push(input logic [17:0] r, input int c);
        exp_t e;
        e.rec = r;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Delta at capture offset c is c - m_anchor, saturated to 16 bits.
    task automatic model_event(input int cs, input int t, input logic [7:0] b);
        int d;
        d = t - m_anchor;
        if (d > 65535) d = 65535;
        if (d <= 7) begin
            push(data_rec(b, d), cs + t + 1);
            m_anchor  = t;
            m_last_wr = cs + t + 1;
        end else begin
            push(time_rec(d), cs + t + 1);
            push(data_rec(b, 0), cs + t + 2);
            m_anchor  = t + 1;
            m_last_wr = cs + t + 2;
        end
        m_count++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge fe_clk);
            mcyc++;
            if (O_fifo_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got 0x%05h at cycle %0d, expected no write",
                             O_fifo_din, mcyc);
                end else begin
                    e = exp_q.pop_front();
                    check("record", 32'(O_fifo_din), 32'(e.rec));
                    check("write_cycle", mcyc, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge fe_clk);
            dcyc++;
        end
    endtask

    task automatic goto_cyc(input int target);
        if (dcyc > target) begin
            checks++;
            failures++;
            $display("FAIL schedule: at cycle %0d, required cycle %0d", dcyc, target);
        end
        while (dcyc < target) step();
    endtask

    task automatic drive_event(input int target, input logic [7:0] b);
        goto_cyc(target);
        I_fe_data       = b;
        I_fe_data_valid = 1'b1;
        step();
        I_fe_data_valid = 1'b0;
    endtask

    task automatic arm_and_trigger(input int dly, input int len, output int cs);
        int t;
        I_trigger_delay = 16'(dly);
        I_capture_len   = 16'(len);
        I_arm           = 1'b1;
        step();
        I_arm = 1'b0;
        check("armed_after_arm", 32'(O_armed), 1);
        check("count_cleared", 32'(O_event_count), 0);
        check("overflow_cleared", 32'(O_overflow), 0);
        I_trigger = 1'b1;
        t = dcyc;
        step();
        I_trigger = 1'b0;
        cs        = t + 1 + dly;
        m_anchor  = 0;
        m_count   = 0;
    endtask

    task automatic do_abort();
        I_abort = 1'b1;
        step();
        I_abort = 1'b0;
    endtask

    initial begin : driver
        int          cs, t, len, dly, bad;
        logic [7:0]  b;
        reset_i = 1'b1;
        I_arm = 0; I_abort = 0; I_trigger = 0;
        I_trigger_delay = 0; I_capture_len = 0;
        I_fe_data = 0; I_fe_data_valid = 0; I_fifo_full = 0;
        step(3);
        check("rst_fifo_wr", 32'(O_fifo_wr), 0);
        check("rst_din", 32'(O_fifo_din), 0);
        check("rst_cap_en", 32'(O_capture_enable), 0);
        check("rst_armed", 32'(O_armed), 0);
        check("rst_done", 32'(O_done), 0);
        check("rst_count", 32'(O_event_count), 0);
        reset_i = 1'b0;
        step();

        // Length 3, events at capture offsets 0, 2, 5; an arm pulse mid-capture is ignored.
        arm_and_trigger(0, 3, cs);
        b = 8'(($urandom)); model_event(cs, 0, b); drive_event(cs + 0, b);
        I_arm = 1'b1; step(); I_arm = 1'b0;
        b = 8'(($urandom)); model_event(cs, 2, b); drive_event(cs + 2, b);
        b = 8'(($urandom)); model_event(cs, 5, b); drive_event(cs + 5, b);
        goto_cyc(cs + 6);
        check("len3_done_not_yet", 32'(O_done), 0);
        check("len3_cap_en_final_write", 32'(O_capture_enable), 1);
        step();
        check("len3_done", 32'(O_done), 1);
        check("len3_cap_en_off", 32'(O_capture_enable), 0);
        check("len3_count", 32'(O_event_count), 3);
        check("len3_overflow", 32'(O_overflow), 0);
        step(2);
        check("len3_drained", exp_q.size(), 0);

        // Trigger delay 10: capture starts 11 cycles after the trigger cycle.
        arm_and_trigger(10, 0, cs);
        bad = 0;
        while (dcyc < cs) begin
            if (O_armed !== 1'b1 || O_capture_enable !== 1'b0) bad++;
            step();
        end
        check("delay_armed_throughout", bad, 0);
        check("delay_cap_en_rise", 32'(O_capture_enable), 1);
        check("delay_armed_fall", 32'(O_armed), 0);
        do_abort();
        check("abort_cap_en", 32'(O_capture_enable), 0);
        check("abort_armed", 32'(O_armed), 0);

        // Abort wins over a simultaneous arm.
        I_arm = 1'b1; I_abort = 1'b1; step(); I_arm = 1'b0; I_abort = 1'b0;
        check("abort_beats_arm", 32'(O_armed), 0);

        // Single event at delta 20: TIME then DATA with short delta 0.
        arm_and_trigger(0, 1, cs);
        b = 8'(($urandom)); model_event(cs, 20, b); drive_event(cs + 20, b);
        goto_cyc(m_last_wr + 1);
        check("d20_done", 32'(O_done), 1);
        check("d20_count", 32'(O_event_count), 1);

        // Randomised captures, re-armed from DONE each time.
        for (int it = 0; it < 20; it++) begin
            dly = $urandom_range(0, 12);
            len = $urandom_range(1, 6);
            arm_and_trigger(dly, len, cs);
            t = $urandom_range(0, 4);
            for (int k = 0; k < len; k++) begin
                b = 8'(($urandom));
                model_event(cs, t, b);
                drive_event(cs + t, b);
                t += $urandom_range(2, 25);
            end
            drive_event(cs + t, 8'hA5);
            step();
            check("rand_done", 32'(O_done), 1);
            check("rand_count", 32'(O_event_count), len);
            check("rand_overflow", 32'(O_overflow), 0);
        end
        step(2);
        check("rand_drained", exp_q.size(), 0);

        // FIFO full drops a TIME record together with its pending DATA.
        arm_and_trigger(0, 0, cs);
        b = 8'(($urandom)); model_event(cs, 1, b); drive_event(cs + 1, b);
        goto_cyc(cs + 12);
        I_fifo_full = 1'b1;
        drive_event(cs + 12, 8'h5A);
        step(2);
        check("full_overflow", 32'(O_overflow), 1);
        check("full_done", 32'(O_done), 1);
        check("full_cap_en", 32'(O_capture_enable), 0);
        check("full_count", 32'(O_event_count), 1);
        I_fifo_full = 1'b0;
        arm_and_trigger(0, 0, cs);
        do_abort();

        // Collision: an event while the pending DATA holds the slot.
        arm_and_trigger(0, 0, cs);
        b = 8'(($urandom)); model_event(cs, 10, b); drive_event(cs + 10, b);
        drive_event(cs + 11, 8'h3C);
        step();
        check("coll_overflow", 32'(O_overflow), 1);
        check("coll_done", 32'(O_done), 1);
        check("coll_count", 32'(O_event_count), 1);
        step(2);
        check("coll_drained", exp_q.size(), 0);

        // Abort with a pending DATA: only the TIME record is written.
        arm_and_trigger(0, 0, cs);
        push(time_rec(15), cs + 16);
        drive_event(cs + 15, 8'h77);
        do_abort();
        check("abort_pend_cap_en", 32'(O_capture_enable), 0);
        check("abort_pend_done", 32'(O_done), 0);
        step(4);
        check("abort_pend_drained", exp_q.size(), 0);

        // Reset mid-capture with a pending DATA.
        arm_and_trigger(0, 0, cs);
        b = 8'(($urandom)); model_event(cs, 2, b); drive_event(cs + 2, b);
        push(time_rec(13), cs + 16);
        drive_event(cs + 15, 8'h99);
        reset_i = 1'b1; step(); reset_i = 1'b0;
        check("rstmid_cap_en", 32'(O_capture_enable), 0);
        check("rstmid_count", 32'(O_event_count), 0);
        check("rstmid_fifo_wr", 32'(O_fifo_wr), 0);
        step(4);
        check("rstmid_drained", exp_q.size(), 0);

        // Long idle gap saturates the full delta.
        arm_and_trigger(0, 0, cs);
        b = 8'(($urandom)); model_event(cs, 70000, b); drive_event(cs + 70000, b);
        step(3);
        check("sat_count", 32'(O_event_count), 1);
        do_abort();
        step(3);
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
